// File: rtl/bcd_down_timer_if.sv
// rtl/bcd_down_timer_if.sv - control and status bundle for the two-digit BCD down-timer
interface bcd_down_timer_if;
    logic       Load;
    logic [7:0] D_load;
    logic       Count;
    logic [7:0] A_count;
    logic       Busy;
    logic       Done;
    logic       Zero_pulse;

    modport master (
        output Load, D_load, Count,
        input  A_count, Busy, Done, Zero_pulse
    );

    modport slave (
        input  Load, D_load, Count,
        output A_count, Busy, Done, Zero_pulse
    );
endinterface

// File: rtl/bcd_down_timer.sv
// rtl/bcd_down_timer.sv - two-digit BCD down-counter with preset, done status and zero pulse
module bcd_down_timer #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic              CLK,
    input  logic              reset,
    bcd_down_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] count_q, count_nxt;
    logic [7:0] preset_q, preset_nxt;
    logic [7:0] clamped;
    logic [7:0] decremented;
    logic       zero_q, zero_nxt;
    logic       busy_q, done_q;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // RUN never holds 00, so the tens borrow below cannot underflow.
    always_comb begin
        clamped     = {clamp_digit(bus.D_load[7:4]), clamp_digit(bus.D_load[3:0])};
        decremented = (count_q[3:0] != 4'd0)
                    ? {count_q[7:4], count_q[3:0] - 4'd1}
                    : {count_q[7:4] - 4'd1, 4'd9};
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count_q;
        preset_nxt = preset_q;
        zero_nxt   = 1'b0;
        if (bus.Load) begin
            preset_nxt = clamped;
            count_nxt  = clamped;
            state_nxt  = (clamped != 8'h00) ? S_RUN : S_DONE;
        end else if (bus.Count) begin
            case (state)
                S_RUN: begin
                    count_nxt = decremented;
                    if (decremented == 8'h00) begin
                        state_nxt = S_DONE;
                        zero_nxt  = 1'b1;
                    end
                end
                S_DONE: begin
                    // Reload costs one Count, giving a period of preset+1.
                    if (AUTO_RELOAD && (preset_q != 8'h00)) begin
                        count_nxt = preset_q;
                        state_nxt = S_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            count_q  <= 8'h00;
            preset_q <= 8'h00;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            count_q  <= count_nxt;
            preset_q <= preset_nxt;
            zero_q   <= zero_nxt;
            busy_q   <= (state_nxt == S_RUN);
            done_q   <= (state_nxt == S_DONE);
        end
    end

    assign bus.A_count    = count_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.Zero_pulse = zero_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// tb/tb_bcd_down_timer.sv - bench for bcd_down_timer, hold and auto-reload variants side by side
module tb_bcd_down_timer;

    logic CLK   = 1'b0;
    logic reset = 1'b1;

    bcd_down_timer_if if0 ();
    bcd_down_timer_if if1 ();

    bcd_down_timer #(.AUTO_RELOAD(1'b0)) dut0 (.CLK(CLK), .reset(reset), .bus(if0.slave));
    bcd_down_timer #(.AUTO_RELOAD(1'b1)) dut1 (.CLK(CLK), .reset(reset), .bus(if1.slave));

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Model: decimal value 0..99; mode 0=idle 1=run 2=done.
    int m_val[2];
    int m_pre[2];
    int m_st[2];
    int m_zp[2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_val[k] = 0; m_pre[k] = 0; m_st[k] = 0; m_zp[k] = 0;
        end
    end

    function automatic void check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int to_bcd(int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    always @(posedge CLK or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_val[k] = 0; m_pre[k] = 0; m_st[k] = 0; m_zp[k] = 0;
            end else begin
                int t, o;
                m_zp[k] = 0;
                if (if0.Load) begin
                    t = int'(if0.D_load[7:4]); if (t > 9) t = 9;
                    o = int'(if0.D_load[3:0]); if (o > 9) o = 9;
                    m_pre[k] = t * 10 + o;
                    m_val[k] = m_pre[k];
                    m_st[k]  = (m_val[k] != 0) ? 1 : 2;
                end else if (if0.Count) begin
                    if (m_st[k] == 1) begin
                        m_val[k] = m_val[k] - 1;
                        if (m_val[k] == 0) begin
                            m_st[k] = 2;
                            m_zp[k] = 1;
                        end
                    end else if (m_st[k] == 2 && k == 1 && m_pre[k] != 0) begin
                        m_val[k] = m_pre[k];
                        m_st[k]  = 1;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            check("cyc0 A_count",    int'(if0.A_count),    to_bcd(m_val[0]));
            check("cyc0 Busy",       int'(if0.Busy),       int'(m_st[0] == 1));
            check("cyc0 Done",       int'(if0.Done),       int'(m_st[0] == 2));
            check("cyc0 Zero_pulse", int'(if0.Zero_pulse), m_zp[0]);
            check("cyc1 A_count",    int'(if1.A_count),    to_bcd(m_val[1]));
            check("cyc1 Busy",       int'(if1.Busy),       int'(m_st[1] == 1));
            check("cyc1 Done",       int'(if1.Done),       int'(m_st[1] == 2));
            check("cyc1 Zero_pulse", int'(if1.Zero_pulse), m_zp[1]);
        end
    end

    task automatic tick(input bit l, input logic [7:0] d, input bit c);
        if0.Load = l; if0.D_load = d; if0.Count = c;
        if1.Load = l; if1.D_load = d; if1.Count = c;
        @(negedge CLK);
    endtask

    initial begin
        if0.Load = 1'b0; if0.D_load = 8'h00; if0.Count = 1'b0;
        if1.Load = 1'b0; if1.D_load = 8'h00; if1.Count = 1'b0;
        @(negedge CLK);
        chk_on = 1'b1;
        tick(0, 8'h00, 0);
        reset = 1'b0;
        tick(0, 8'h00, 0);
        #1;
        check("reset A_count", int'(if0.A_count), 8'h00);
        check("reset Busy/Done", int'({if0.Busy, if0.Done, if0.Zero_pulse}), 0);

        // Count is ignored in IDLE
        tick(0, 8'h00, 1);
        tick(0, 8'h00, 1);
        #1;
        check("idle ignores Count", int'(if0.A_count), 8'h00);
        check("idle Busy", int'(if0.Busy), 0);

        // Reset mid-run
        tick(1, 8'h25, 0);
        for (int i = 0; i < 3; i++) tick(0, 8'h00, 1);
        #1;
        check("run to 22", int'(if0.A_count), 8'h22);
        check("run Busy", int'(if0.Busy), 1);
        reset = 1'b1;
        #1;
        check("async reset A_count", int'(if0.A_count), 8'h00);
        check("async reset flags", int'({if1.Busy, if1.Done, if1.Zero_pulse}), 0);
        tick(0, 8'h00, 1);
        reset = 1'b0;
        tick(0, 8'h00, 1);
        tick(0, 8'h00, 1);
        #1;
        check("post-reset idle", int'(if0.A_count), 8'h00);
        check("post-reset Busy", int'(if1.Busy), 0);

        // Countdown with digit borrow
        tick(1, 8'h12, 0);
        for (int i = 1; i <= 12; i++) begin
            tick(0, 8'h00, 1);
            #1;
            if (i == 2)  check("borrow 10", int'(if0.A_count), 8'h10);
            if (i == 3)  check("borrow 09", int'(if0.A_count), 8'h09);
            if (i == 11) check("no early pulse", int'(if0.Zero_pulse), 0);
        end
        check("reach 00", int'(if0.A_count), 8'h00);
        check("zero pulse", int'(if0.Zero_pulse), 1);
        check("done flag", int'({if0.Busy, if0.Done}), 1);
        tick(0, 8'h00, 1);
        #1;
        check("hold 00", int'(if0.A_count), 8'h00);
        check("pulse single", int'(if0.Zero_pulse), 0);
        check("reload 12", int'(if1.A_count), 8'h12);
        check("reload Busy", int'(if1.Busy), 1);

        // Clamp and Load priority
        tick(1, 8'hAF, 0);
        #1;
        check("clamp 99", int'(if0.A_count), 8'h99);
        tick(1, 8'h05, 1);
        #1;
        check("load beats count", int'(if0.A_count), 8'h05);

        // Zero load
        tick(1, 8'h00, 0);
        #1;
        check("zero load flags", int'({if0.Busy, if0.Done, if0.Zero_pulse}), 3'b010);
        tick(0, 8'h00, 1);
        #1;
        check("zero preset no reload", int'(if1.A_count), 8'h00);
        check("zero preset Done", int'(if1.Done), 1);

        // Auto-reload period of 4 with preset 03
        tick(1, 8'h03, 0);
        for (int i = 1; i <= 8; i++) begin
            tick(0, 8'h00, 1);
            #1;
            if (i == 3) check("ar pulse at 00", int'(if1.Zero_pulse), 1);
            if (i == 4) check("ar back to 03", int'(if1.A_count), 8'h03);
            if (i == 4) check("hold variant stays 00", int'(if0.A_count), 8'h00);
            if (i == 7) check("ar second pulse", int'(if1.Zero_pulse), 1);
        end

        // Gapped Count
        tick(1, 8'h10, 0);
        tick(0, 8'h00, 1);
        #1;
        check("gap 09", int'(if0.A_count), 8'h09);
        tick(0, 8'h00, 0);
        #1;
        check("gap hold 09", int'(if0.A_count), 8'h09);
        tick(0, 8'h00, 1);
        tick(0, 8'h00, 0);
        #1;
        check("gap hold 08", int'(if0.A_count), 8'h08);

        tick(0, 8'h00, 0);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
